// File: rtl/rf_writeback_pkg.sv
// Shared core definitions for the integer writeback path:
// load encodings, register address width and writeback bundles.
package rf_writeback_pkg;

  localparam int unsigned REG_AW = 5;
  localparam int unsigned XLEN   = 32;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  typedef logic [REG_AW-1:0] reg_addr_t;
  typedef logic [XLEN-1:0]   xword_t;

  typedef struct packed {
    logic      valid;
    reg_addr_t rd;
    logic [2:0] funct3;
    logic [1:0] off;
  } ld_ent_t;

  typedef struct packed {
    logic      valid;
    reg_addr_t rd;
    xword_t    data;
  } wb_ent_t;

  function automatic logic rd_hit(
    input reg_addr_t a,
    input reg_addr_t b
  );
    return (a != '0) && (a == b);
  endfunction

endpackage

// File: rtl/rf_writeback_load_extend.sv
// Load data alignment: selects the byte/halfword addressed by
// off and sign- or zero-extends it to a full register word.
module load_extend
  import rf_writeback_pkg::*;
(
  input  logic [31:0] rdata_i,
  input  logic [2:0]  funct3_i,
  input  logic [1:0]  off_i,
  output logic [31:0] data_o
);

  logic [31:0] shifted;
  logic [7:0]  byte_v;
  logic [15:0] half_v;

  assign shifted = rdata_i >> {off_i, 3'b000};
  assign byte_v  = shifted[7:0];
  // off[0] is ignored for halfwords; misaligned halves are not split
  assign half_v  = off_i[1] ? rdata_i[31:16] : rdata_i[15:0];

  always_comb begin
    data_o = rdata_i;
    case (funct3_i)
      F3_LB:   data_o = {{24{byte_v[7]}}, byte_v};
      F3_LH:   data_o = {{16{half_v[15]}}, half_v};
      F3_LBU:  data_o = {24'h0, byte_v};
      F3_LHU:  data_o = {16'h0, half_v};
      default: data_o = rdata_i;
    endcase
  end

endmodule

// File: rtl/rf_writeback.sv
// Register file writeback: merges ALU results with fixed-latency
// loads, and supplies bypass values and load-use stall to decode.
module rf_writeback
  import rf_writeback_pkg::*;
#(
  parameter int unsigned LOAD_LAT = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        alu_valid,
  output logic        alu_ready,
  input  logic [4:0]  alu_rd,
  input  logic [31:0] alu_data,
  input  logic        ld_valid,
  input  logic [4:0]  ld_rd,
  input  logic [2:0]  ld_funct3,
  input  logic [1:0]  ld_off,
  input  logic [31:0] dmem_rdata,
  input  logic [4:0]  dec_rs1,
  input  logic [4:0]  dec_rs2,
  input  logic [4:0]  dec_rd,
  output logic        stall,
  output logic        fwd1_valid,
  output logic        fwd2_valid,
  output logic [31:0] fwd1_data,
  output logic [31:0] fwd2_data,
  output logic        rf_we,
  output logic [4:0]  rf_wa,
  output logic [31:0] rf_wd
);

  ld_ent_t   trk_q [LOAD_LAT];
  ld_ent_t   trk_d [LOAD_LAT];
  wb_ent_t   skid_q, skid_d;
  logic      we_q, we_d;
  reg_addr_t wa_q, wa_d;
  xword_t    wd_q, wd_d;

  ld_ent_t   ret;
  xword_t    ld_data;
  logic      alu_acc;
  wb_ent_t   sel;

  assign ret       = trk_q[LOAD_LAT-1];
  assign alu_ready = !skid_q.valid;
  assign alu_acc   = alu_valid && alu_ready;

  load_extend u_ext (
    .rdata_i  (dmem_rdata),
    .funct3_i (ret.funct3),
    .off_i    (ret.off),
    .data_o   (ld_data)
  );

  always_comb begin
    trk_d[0].valid  = ld_valid;
    trk_d[0].rd     = ld_rd;
    trk_d[0].funct3 = ld_funct3;
    trk_d[0].off    = ld_off;
    for (int i = 1; i < LOAD_LAT; i++) begin
      trk_d[i] = trk_q[i-1];
    end
  end

  // returning load owns the port; a colliding ALU result parks in skid
  always_comb begin
    sel    = '0;
    skid_d = skid_q;
    if (ret.valid) begin
      sel = '{valid: 1'b1, rd: ret.rd, data: ld_data};
      if (alu_acc) begin
        skid_d = '{valid: 1'b1, rd: alu_rd, data: alu_data};
      end
    end else if (skid_q.valid) begin
      sel          = skid_q;
      skid_d.valid = 1'b0;
    end else if (alu_acc) begin
      sel = '{valid: 1'b1, rd: alu_rd, data: alu_data};
    end
  end

  always_comb begin
    we_d = sel.valid && (sel.rd != '0);
    wa_d = wa_q;
    wd_d = wd_q;
    if (we_d) begin
      wa_d = sel.rd;
      wd_d = sel.data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < LOAD_LAT; i++) begin
        trk_q[i] <= '0;
      end
      skid_q <= '0;
      we_q   <= 1'b0;
      wa_q   <= '0;
      wd_q   <= '0;
    end else begin
      for (int i = 0; i < LOAD_LAT; i++) begin
        trk_q[i] <= trk_d[i];
      end
      skid_q <= skid_d;
      we_q   <= we_d;
      wa_q   <= wa_d;
      wd_q   <= wd_d;
    end
  end

  assign rf_we = we_q;
  assign rf_wa = wa_q;
  assign rf_wd = wd_q;

  always_comb begin
    stall = 1'b0;
    for (int i = 0; i < LOAD_LAT; i++) begin
      if (trk_q[i].valid &&
          (rd_hit(trk_q[i].rd, dec_rs1) ||
           rd_hit(trk_q[i].rd, dec_rs2) ||
           rd_hit(trk_q[i].rd, dec_rd))) begin
        stall = 1'b1;
      end
    end
  end

  // skid holds the younger value, so it wins over the port
  always_comb begin
    fwd1_valid = 1'b0;
    fwd1_data  = '0;
    if (skid_q.valid && rd_hit(skid_q.rd, dec_rs1)) begin
      fwd1_valid = 1'b1;
      fwd1_data  = skid_q.data;
    end else if (we_q && rd_hit(wa_q, dec_rs1)) begin
      fwd1_valid = 1'b1;
      fwd1_data  = wd_q;
    end
  end

  always_comb begin
    fwd2_valid = 1'b0;
    fwd2_data  = '0;
    if (skid_q.valid && rd_hit(skid_q.rd, dec_rs2)) begin
      fwd2_valid = 1'b1;
      fwd2_data  = skid_q.data;
    end else if (we_q && rd_hit(wa_q, dec_rs2)) begin
      fwd2_valid = 1'b1;
      fwd2_data  = wd_q;
    end
  end

endmodule

// File: tb/tb_rf_writeback.sv
// Directed bench for rf_writeback with LOAD_LAT = 1.
// Inputs change 1ns after each rising edge; outputs checked after.
module tb_rf_writeback;

  logic        clk = 1'b0;
  logic        rst;
  logic        alu_valid, alu_ready;
  logic [4:0]  alu_rd;
  logic [31:0] alu_data;
  logic        ld_valid;
  logic [4:0]  ld_rd;
  logic [2:0]  ld_funct3;
  logic [1:0]  ld_off;
  logic [31:0] dmem_rdata;
  logic [4:0]  dec_rs1, dec_rs2, dec_rd;
  logic        stall, fwd1_valid, fwd2_valid;
  logic [31:0] fwd1_data, fwd2_data;
  logic        rf_we;
  logic [4:0]  rf_wa;
  logic [31:0] rf_wd;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  rf_writeback #(.LOAD_LAT(1)) dut (
    .clk        (clk),
    .rst        (rst),
    .alu_valid  (alu_valid),
    .alu_ready  (alu_ready),
    .alu_rd     (alu_rd),
    .alu_data   (alu_data),
    .ld_valid   (ld_valid),
    .ld_rd      (ld_rd),
    .ld_funct3  (ld_funct3),
    .ld_off     (ld_off),
    .dmem_rdata (dmem_rdata),
    .dec_rs1    (dec_rs1),
    .dec_rs2    (dec_rs2),
    .dec_rd     (dec_rd),
    .stall      (stall),
    .fwd1_valid (fwd1_valid),
    .fwd2_valid (fwd2_valid),
    .fwd1_data  (fwd1_data),
    .fwd2_data  (fwd2_data),
    .rf_we      (rf_we),
    .rf_wa      (rf_wa),
    .rf_wd      (rf_wd)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    rst = 1'b1;
    alu_valid = 0; alu_rd = 0; alu_data = 0;
    ld_valid = 0; ld_rd = 0; ld_funct3 = 0; ld_off = 0;
    dmem_rdata = 0; dec_rs1 = 0; dec_rs2 = 0; dec_rd = 0;
    tick();
    tick();
    chk("rst_we", {31'b0, rf_we}, 32'd0);
    chk("rst_wa", {27'b0, rf_wa}, 32'd0);
    chk("rst_wd", rf_wd, 32'd0);
    chk("rst_ready", {31'b0, alu_ready}, 32'd1);
    chk("rst_stall", {31'b0, stall}, 32'd0);
    chk("rst_fwd1", {31'b0, fwd1_valid}, 32'd0);
    rst = 1'b0;

    // ALU write to x5, then bypass to rs1
    alu_valid = 1; alu_rd = 5; alu_data = 32'h1234_5678;
    tick();
    alu_valid = 0; dec_rs1 = 5;
    settle();
    chk("alu_we", {31'b0, rf_we}, 32'd1);
    chk("alu_wa", {27'b0, rf_wa}, 32'd5);
    chk("alu_wd", rf_wd, 32'h1234_5678);
    chk("alu_fwd1v", {31'b0, fwd1_valid}, 32'd1);
    chk("alu_fwd1d", fwd1_data, 32'h1234_5678);
    dec_rs1 = 0;

    // four back-to-back sub-word loads
    ld_valid = 1; ld_rd = 1; ld_funct3 = 3'b000; ld_off = 3;
    tick();
    dmem_rdata = 32'h80FF_7F01;
    ld_rd = 2; ld_funct3 = 3'b100; ld_off = 1;
    tick();
    chk("lb_we", {31'b0, rf_we}, 32'd1);
    chk("lb_wa", {27'b0, rf_wa}, 32'd1);
    chk("lb_wd", rf_wd, 32'hFFFF_FF80);
    ld_rd = 3; ld_funct3 = 3'b001; ld_off = 2;
    tick();
    chk("lbu_wa", {27'b0, rf_wa}, 32'd2);
    chk("lbu_wd", rf_wd, 32'h0000_007F);
    ld_rd = 4; ld_funct3 = 3'b101; ld_off = 0;
    tick();
    chk("lh_wa", {27'b0, rf_wa}, 32'd3);
    chk("lh_wd", rf_wd, 32'hFFFF_80FF);
    ld_valid = 0;
    tick();
    chk("lhu_we", {31'b0, rf_we}, 32'd1);
    chk("lhu_wa", {27'b0, rf_wa}, 32'd4);
    chk("lhu_wd", rf_wd, 32'h0000_7F01);
    tick();
    chk("idle_we", {31'b0, rf_we}, 32'd0);

    // load x6 returns while ALU x7 is accepted
    ld_valid = 1; ld_rd = 6; ld_funct3 = 3'b010; ld_off = 0;
    tick();
    ld_valid = 0; dmem_rdata = 32'hCAFE_BABE;
    alu_valid = 1; alu_rd = 7; alu_data = 32'h0000_0777;
    settle();
    chk("col_ready0", {31'b0, alu_ready}, 32'd1);
    tick();
    alu_valid = 0; dec_rs2 = 7;
    settle();
    chk("col_we6", {31'b0, rf_we}, 32'd1);
    chk("col_wa6", {27'b0, rf_wa}, 32'd6);
    chk("col_wd6", rf_wd, 32'hCAFE_BABE);
    chk("col_ready1", {31'b0, alu_ready}, 32'd0);
    chk("col_fwd2v", {31'b0, fwd2_valid}, 32'd1);
    chk("col_fwd2d", fwd2_data, 32'h0000_0777);
    tick();
    chk("col_we7", {31'b0, rf_we}, 32'd1);
    chk("col_wa7", {27'b0, rf_wa}, 32'd7);
    chk("col_wd7", rf_wd, 32'h0000_0777);
    chk("col_ready2", {31'b0, alu_ready}, 32'd1);
    dec_rs2 = 0;

    // load-use stall on x8
    ld_valid = 1; ld_rd = 8; dec_rs1 = 8;
    settle();
    chk("st_issue", {31'b0, stall}, 32'd0);
    tick();
    ld_valid = 0; dmem_rdata = 32'h1111_2222;
    settle();
    chk("st_rs1", {31'b0, stall}, 32'd1);
    dec_rs1 = 0; dec_rd = 8;
    settle();
    chk("st_rd", {31'b0, stall}, 32'd1);
    dec_rd = 0;
    settle();
    chk("st_none", {31'b0, stall}, 32'd0);
    dec_rs1 = 8;
    tick();
    chk("st_we", {31'b0, rf_we}, 32'd1);
    chk("st_wa", {27'b0, rf_wa}, 32'd8);
    chk("st_wd", rf_wd, 32'h1111_2222);
    chk("st_after", {31'b0, stall}, 32'd0);
    chk("st_fwd1d", fwd1_data, 32'h1111_2222);

    // load to x0: no stall, no write
    dec_rs1 = 0; ld_valid = 1; ld_rd = 0;
    tick();
    ld_valid = 0; dmem_rdata = 32'hDEAD_BEEF;
    settle();
    chk("x0_stall", {31'b0, stall}, 32'd0);
    tick();
    chk("x0_we", {31'b0, rf_we}, 32'd0);

    // rst one cycle after issue discards the load
    ld_valid = 1; ld_rd = 9; dec_rs1 = 9;
    tick();
    ld_valid = 0; rst = 1; dmem_rdata = 32'h5555_AAAA;
    tick();
    rst = 0;
    settle();
    chk("rr_we0", {31'b0, rf_we}, 32'd0);
    chk("rr_ready", {31'b0, alu_ready}, 32'd1);
    chk("rr_stall", {31'b0, stall}, 32'd0);
    tick();
    chk("rr_we1", {31'b0, rf_we}, 32'd0);
    tick();
    chk("rr_we2", {31'b0, rf_we}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
